// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// register count, FSM state encoding and a small modulo helper.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    // ARB: normal arbitration, CLEAR: zero-fill r1..r31, DONE: one-cycle completion.
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } arbState_t;

    // Index following idx in a ring of n entries.
    function automatic int wrapIncrement(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: picks the first requester at or above the pointer,
// wrapping to the lowest requester when nothing at or above it is asking.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] highMask;
    logic [NUM_REQ-1:0] maskedReq;
    logic [NUM_REQ-1:0] maskedGrant;
    logic [NUM_REQ-1:0] plainGrant;

    // Bits at or above the pointer carry the current highest priority.
    assign highMask    = ~((NUM_REQ'(1) << pointer) - NUM_REQ'(1));
    assign maskedReq   = request & highMask;

    // Isolate the lowest set bit of each candidate vector (x & -x).
    assign maskedGrant = maskedReq & (~maskedReq + NUM_REQ'(1));
    assign plainGrant  = request & (~request + NUM_REQ'(1));

    assign grant = (|maskedReq) ? maskedGrant : plainGrant;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates several register-file write requesters onto one registered write
// port, and can zero-fill r1..r31 on request while holding requesters off.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      clock,
    input  logic                      ctrl_reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      clear_start,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      ctrl_writeEnable,
    output logic [ADDR_W-1:0]         ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] FIRST_CLEAR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_CLEAR  = ADDR_W'(NUM_REGS - 1);

    arbState_t          stateReg, stateNext;
    logic [PTR_W-1:0]   ptrReg, ptrNext;
    logic [ADDR_W-1:0]  clearIdxReg, clearIdxNext;
    logic               writeEnableReg, writeEnableNext;
    logic [ADDR_W-1:0]  writeRegReg, writeRegNext;
    logic [DATA_W-1:0]  writeDataReg, writeDataNext;

    logic [NUM_REQ-1:0] grant;
    logic               arbActive;
    logic               transfer;
    logic [PTR_W-1:0]   grantIdx;
    logic [ADDR_W-1:0]  selAddr;
    logic [DATA_W-1:0]  selData;

    logic [ADDR_W-1:0]  reqAddrArr [NUM_REQ];
    logic [DATA_W-1:0]  reqDataArr [NUM_REQ];

    // Split the packed request buses into per-requester slices.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
        assign reqAddrArr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign reqDataArr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) uRrArbiter (
        .request (req_valid),
        .pointer (ptrReg),
        .grant   (grant)
    );

    // A grant is only offered in ARB, never in a cycle that starts a clear,
    // and never while reset is held.
    assign req_ready = (arbActive && ctrl_reset_n) ? grant : '0;
    assign transfer  = |req_ready;

    // FSM state register.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            stateReg <= ARB;
        end else begin
            stateReg <= stateNext;
        end
    end

    // FSM next-state: ARB -> CLEAR on request, CLEAR runs to r31, DONE lasts one cycle.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ARB:     if (clear_start) stateNext = CLEAR;
            CLEAR:   if (clearIdxReg == LAST_CLEAR) stateNext = DONE;
            DONE:    stateNext = ARB;
            default: stateNext = ARB;
        endcase
    end

    // FSM outputs: arbitration enable and the clear status flags.
    always_comb begin
        arbActive  = 1'b0;
        clear_busy = 1'b0;
        clear_done = 1'b0;
        case (stateReg)
            ARB:     arbActive  = !clear_start;
            CLEAR:   clear_busy = 1'b1;
            DONE:    clear_done = 1'b1;
            default: arbActive  = 1'b0;
        endcase
    end

    // Convert the one-hot grant into an index and select that requester's payload.
    always_comb begin
        grantIdx = '0;
        selAddr  = '0;
        selData  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grantIdx = PTR_W'(i);
                selAddr  = reqAddrArr[i];
                selData  = reqDataArr[i];
            end
        end
    end

    // Write-port, pointer and clear-index next values.
    // The clear index names the register currently shown on the write port,
    // so the fill writes line up exactly with the CLEAR cycles.
    always_comb begin
        writeEnableNext = 1'b0;
        writeRegNext    = writeRegReg;
        writeDataNext   = writeDataReg;
        ptrNext         = ptrReg;
        clearIdxNext    = clearIdxReg;
        case (stateReg)
            ARB: begin
                if (clear_start) begin
                    writeEnableNext = 1'b1;
                    writeRegNext    = FIRST_CLEAR;
                    writeDataNext   = '0;
                    clearIdxNext    = FIRST_CLEAR;
                end else if (transfer) begin
                    ptrNext = PTR_W'(wrapIncrement(int'(grantIdx), NUM_REQ));
                    // r0 is hardwired: accept the request but do not write it.
                    if (selAddr != '0) begin
                        writeEnableNext = 1'b1;
                        writeRegNext    = selAddr;
                        writeDataNext   = selData;
                    end
                end
            end
            CLEAR: begin
                if (clearIdxReg != LAST_CLEAR) begin
                    writeEnableNext = 1'b1;
                    writeRegNext    = clearIdxReg + ADDR_W'(1);
                    writeDataNext   = '0;
                    clearIdxNext    = clearIdxReg + ADDR_W'(1);
                end else begin
                    clearIdxNext    = FIRST_CLEAR;
                end
            end
            default: begin
                writeEnableNext = 1'b0;
            end
        endcase
    end

    // Datapath registers: write port, round-robin pointer and clear index.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            writeEnableReg <= 1'b0;
            writeRegReg    <= '0;
            writeDataReg   <= '0;
            ptrReg         <= '0;
            clearIdxReg    <= FIRST_CLEAR;
        end else begin
            writeEnableReg <= writeEnableNext;
            writeRegReg    <= writeRegNext;
            writeDataReg   <= writeDataNext;
            ptrReg         <= ptrNext;
            clearIdxReg    <= clearIdxNext;
        end
    end

    assign ctrl_writeEnable = writeEnableReg;
    assign ctrl_writeReg    = writeRegReg;
    assign data_writeReg    = writeDataReg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus pushes expected writes, a monitor pops and
// compares them whenever the write port fires.
module tb_regfile_write_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic             clock = 1'b0;
    logic             ctrl_reset_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic             clear_start;
    logic             clear_busy;
    logic             clear_done;
    logic             ctrl_writeEnable;
    logic [AW-1:0]    ctrl_writeReg;
    logic [DW-1:0]    data_writeReg;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t expQ[$];
    int  checks = 0;
    int  errors = 0;

    logic [AW-1:0] burstAddr  [NR] = '{5'd7, 5'd8, 5'd9};
    logic [DW-1:0] burstData  [NR] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};
    logic [NR-1:0] burstOrder [6]  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    int            burstIdx   [6]  = '{0, 1, 2, 0, 1, 2};

    always #5 clock = ~clock;

    regfile_write_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .clear_start      (clear_start),
        .clear_busy       (clear_busy),
        .clear_done       (clear_done),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setReq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic setBurst();
        for (int i = 0; i < NR; i++) setReq(i, burstAddr[i], burstData[i]);
        req_valid = '1;
    endtask

    task automatic pushClear();
        for (int k = 1; k < 32; k++) expQ.push_back('{addr: AW'(k), data: '0});
    endtask

    // Monitor: every write-port pulse must match the oldest expected write.
    always @(posedge clock) begin
        wr_t e;
        #3;
        if (ctrl_writeEnable === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got r%0d=0x%08h, expected no write", ctrl_writeReg, data_writeReg);
            end else begin
                e = expQ.pop_front();
                check("write_addr", 64'(ctrl_writeReg), 64'(e.addr));
                check("write_data", 64'(data_writeReg), 64'(e.data));
                $display("write r%0d <= 0x%08h (expected r%0d <= 0x%08h)", ctrl_writeReg, data_writeReg, e.addr, e.data);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctrl_reset_n = 1'b0;
        clear_start  = 1'b0;
        req_addr     = '0;
        req_data     = '0;
        req_valid    = '1;
        #2;
        check("reset_ready", 64'(req_ready), 64'd0);
        check("reset_we", 64'(ctrl_writeEnable), 64'd0);
        check("reset_reg", 64'(ctrl_writeReg), 64'd0);
        check("reset_data", 64'(data_writeReg), 64'd0);
        check("reset_busy", 64'(clear_busy), 64'd0);
        check("reset_done", 64'(clear_done), 64'd0);
        req_valid = '0;
        #20 ctrl_reset_n = 1'b1;

        // Three requesters held valid for six cycles: 0,1,2,0,1,2 back to back.
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) setBurst();
            else check("burst_gapless_we", 64'(ctrl_writeEnable), 64'd1);
            #1;
            check("burst_grant", 64'(req_ready), 64'(burstOrder[i]));
            expQ.push_back('{addr: burstAddr[burstIdx[i]], data: burstData[burstIdx[i]]});
        end
        tick();
        check("burst_last_we", 64'(ctrl_writeEnable), 64'd1);

        // Single request from requester 0.
        req_valid = '0;
        setReq(0, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b001;
        #1;
        check("single_ready", 64'(req_ready), 64'b001);
        expQ.push_back('{addr: 5'd5, data: 32'hDEAD_BEEF});
        tick();
        check("single_we", 64'(ctrl_writeEnable), 64'd1);
        req_valid = '0;
        tick();
        check("single_we_pulse", 64'(ctrl_writeEnable), 64'd0);
        check("single_reg_hold", 64'(ctrl_writeReg), 64'd5);

        // Write to r0: accepted, no write, pointer moves past requester 1.
        setReq(1, 5'd0, 32'h0000_1234);
        req_valid = 3'b010;
        #1;
        check("addr0_ready", 64'(req_ready), 64'b010);
        tick();
        check("addr0_no_we", 64'(ctrl_writeEnable), 64'd0);
        check("addr0_reg_hold", 64'(ctrl_writeReg), 64'd5);
        check("addr0_data_hold", 64'(data_writeReg), 64'hDEAD_BEEF);
        setBurst();
        #1;
        check("ptr_after_addr0", 64'(req_ready), 64'b100);
        expQ.push_back('{addr: burstAddr[2], data: burstData[2]});
        tick();
        check("ptr_after_addr0_we", 64'(ctrl_writeEnable), 64'd1);
        req_valid = '0;

        // Clear with requester 0 waiting; re-pulse mid-fill and during DONE.
        tick();
        setReq(0, 5'd3, 32'h0000_A5A5);
        req_valid   = 3'b001;
        clear_start = 1'b1;
        #1;
        check("clear_start_ready", 64'(req_ready), 64'd0);
        pushClear();
        for (int k = 1; k < 32; k++) begin
            tick();
            check("clear_busy", 64'(clear_busy), 64'd1);
            check("clear_we", 64'(ctrl_writeEnable), 64'd1);
            check("clear_no_done", 64'(clear_done), 64'd0);
            clear_start = (k == 15);
            #1;
            check("clear_ready", 64'(req_ready), 64'd0);
        end
        tick();
        check("done_pulse", 64'(clear_done), 64'd1);
        check("done_busy", 64'(clear_busy), 64'd0);
        check("done_we", 64'(ctrl_writeEnable), 64'd0);
        clear_start = 1'b1;
        #1;
        check("done_ready", 64'(req_ready), 64'd0);
        tick();
        check("after_done_pulse", 64'(clear_done), 64'd0);
        check("after_done_busy", 64'(clear_busy), 64'd0);
        clear_start = 1'b0;
        #1;
        check("after_done_ready", 64'(req_ready), 64'b001);
        expQ.push_back('{addr: 5'd3, data: 32'h0000_A5A5});
        tick();
        check("after_done_we", 64'(ctrl_writeEnable), 64'd1);

        // Pointer is unaffected by the clear: requester 1 is next.
        setBurst();
        #1;
        check("ptr_after_clear", 64'(req_ready), 64'b010);
        expQ.push_back('{addr: burstAddr[1], data: burstData[1]});
        tick();
        check("ptr_after_clear_we", 64'(ctrl_writeEnable), 64'd1);
        req_valid = '0;

        // Reset in the 10th clear cycle aborts the fill.
        tick();
        clear_start = 1'b1;
        #1;
        check("clear2_start_ready", 64'(req_ready), 64'd0);
        pushClear();
        for (int k = 1; k <= 10; k++) begin
            tick();
            clear_start = 1'b0;
            check("clear2_we", 64'(ctrl_writeEnable), 64'd1);
            check("clear2_busy", 64'(clear_busy), 64'd1);
        end
        check("clear2_reg10", 64'(ctrl_writeReg), 64'd10);
        #4;
        ctrl_reset_n = 1'b0;
        #1;
        check("abort_we", 64'(ctrl_writeEnable), 64'd0);
        check("abort_busy", 64'(clear_busy), 64'd0);
        check("abort_done", 64'(clear_done), 64'd0);
        check("abort_reg", 64'(ctrl_writeReg), 64'd0);
        check("abort_pending", 64'(expQ.size()), 64'd21);
        expQ.delete();
        @(posedge clock);
        #3 ctrl_reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_abort_done", 64'(clear_done), 64'd0);
            check("post_abort_busy", 64'(clear_busy), 64'd0);
            check("post_abort_we", 64'(ctrl_writeEnable), 64'd0);
        end
        setBurst();
        #1;
        check("ptr_after_reset", 64'(req_ready), 64'b001);
        expQ.push_back('{addr: burstAddr[0], data: burstData[0]});
        tick();
        check("ptr_after_reset_we", 64'(ctrl_writeEnable), 64'd1);
        req_valid = '0;
        tick();
        tick();
        check("scoreboard_drained", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
